// File: rtl/mux_arb_pkg.sv
// Purpose: shared constants, state encoding and helpers for the 4-way round-robin mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_st_t;

    // Expand an encoded requester index into a one-hot vector.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_4x1.sv
// Purpose: 1-bit 4:1 mux, one lane of the output datapath.
// Latency: combinational.
// Backpressure: none.
module mux_4x1 (
    input  logic [3:0] i,
    input  logic [1:0] sel,
    output logic       y
);

    assign y = i[sel];

endmodule

// File: rtl/rr_pick4.sv
// Purpose: rotate-priority picker; first requester at or after ptr, wrapping 3 -> 0.
// Latency: combinational.
// Backpressure: none; any=0 means nothing to pick and idx is don't-care (0).
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest slot back toward ptr so the nearest requester wins.
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Purpose: round-robin arbiter sharing one DATA_W channel among 4 requesters, bursts up to BURST_MAX.
// Latency: 1 cycle from req to out_valid; back-to-back grants with no idle bubble.
// Backpressure: out_ready low holds the grant and the beat count indefinitely; beat_ack only on transfer.
module rr_mux_arbiter_4
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [SEL_W-1:0]        sel,
    output logic [N_REQ-1:0]        beat_ack
);

    localparam int CNT_W = $clog2(BURST_MAX) + 1;

    arb_st_t          state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic             busy;
    logic             xfer;
    logic             last_beat;
    logic             release_gnt;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    assign busy      = (state == ST_GRANT);
    assign out_valid = busy & req[sel];
    assign xfer      = out_valid & out_ready;
    assign beat_ack  = xfer ? onehot(sel) : '0;
    assign last_beat = (beat_cnt == CNT_W'(BURST_MAX - 1));

    // Release on withdrawal, or when the final beat of a burst is accepted.
    assign release_gnt = busy & (~req[sel] | (xfer & last_beat));

    // While granted, pick with the post-release pointer sel+1. That makes the
    // current owner lowest priority, so scanning the full req vector gives the
    // same answer as scanning with the owner masked off, and still falls back
    // to re-granting the owner when it is the only one left requesting.
    assign pick_ptr = busy ? (sel + SEL_W'(1)) : ptr;

    rr_pick4 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grant FSM: state, registered grant/select, round-robin pointer and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state    <= ST_GRANT;
                        gnt      <= onehot(pick_idx);
                        sel      <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_gnt) begin
                        ptr <= sel + SEL_W'(1);
                        if (pick_any) begin
                            gnt      <= onehot(pick_idx);
                            sel      <= pick_idx;
                            beat_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Bit-sliced output mux: lane b selects bit b of the granted requester's word.
    for (genvar b = 0; b < DATA_W; b++) begin : g_lane
        mux_4x1 u_lane (
            .i   ({data_in[3*DATA_W+b], data_in[2*DATA_W+b],
                   data_in[DATA_W+b],   data_in[b]}),
            .sel (sel),
            .y   (out_data[b])
        );
    end

endmodule
